fp_addsub_stream: RTL and testbench
===================================

# fp_addsub_stream

Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor with a valid/ready stream interface, per-operation rounding mode and a sideband tag. It is the next-generation replacement for the fixed half-precision, free-running add/sub pipeline in the FP datapath. The block accepts one operation per cycle, tolerates downstream backpressure without losing or reordering results, and returns the result together with IEEE exception flags.

## Interface
- EXP_W, 5, exponent field width (≥3)
- MAN_W, 10, stored mantissa width, hidden bit excluded (≥2)
- TAG_W, 4, sideband tag width, carried unmodified
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operation present
- in_ready  out  1  block accepts the operation this cycle
- in_a, in_b  in  1+EXP_W+MAN_W each  operands {sign, exp, man}
- in_op  in  1  0 = a+b, 1 = a−b
- in_rm  in  1  0 = round-nearest-even (RNE), 1 = round-toward-zero (RTZ)
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- out_result  out  1+EXP_W+MAN_W  result
- out_flags  out  5  [4] overflow, [3] underflow, [2] div-by-zero (always 0), [1] invalid, [0] inexact
- out_tag  out  TAG_W  tag of this result

## Operation
- Transfer on either side happens when valid && ready in the same cycle.
- Stage S1 (unpack/compare): applies b sign flip for subtraction; classifies NaN/Inf/zero; treats subnormal inputs as zero (DAZ); selects the larger magnitude operand; computes the exponent difference in EXP_W+1 bits.
- Stage S2 (align): right-shifts the smaller significand, MAN_W+1 bits plus guard, round and sticky bits. Shift amounts ≥ MAN_W+3 saturate, leaving only sticky = OR of the significand.
- Stage S3 (add/lzc): performs the effective add or subtract on MAN_W+5 bits (including the carry bit) and counts leading zeros.
- Stage S4 (normalise/round/pack):
  - Normalises the sum and adjusts the exponent.
  - Rounds per rm. RNE rounds half to even; RTZ truncates.
  - Applies mantissa-overflow-on-round renormalisation.
- Special cases:
  - Any NaN input, or Inf−Inf (effective), gives canonical qNaN: sign 0, exp all ones, man MSB=1, rest 0. Inf−Inf sets invalid. An sNaN input (man MSB=0, man≠0) also sets invalid.
  - An Inf operand gives that Inf with no flags.
  - An exact zero sum gives +0, except −0 + −0 (effective), which gives −0.
- Overflow (rounded exp ≥ all ones):
  - RNE: ±Inf.
  - RTZ: ±max-finite.
  - Sets overflow and inexact in both modes.
- Underflow: a normalised exponent below 1 flushes to signed zero and sets underflow and inexact.
- Inexact: set whenever any discarded bit (G|R|S) is nonzero.
- Tag and rm travel with the operation through every stage.

## Timing
- Latency 4 cycles from input transfer to out_valid when out_ready stays high. Throughput 1 op/cycle.
- Each stage k holds a valid bit v_k.
  - ready_k = !v_k || ready_{k+1}, with ready_5 = out_ready. in_ready = ready_1 (combinational).
  - A stage loads when ready_k; it captures a bubble if the upstream stage is empty, so bubbles collapse under stall.
- out_valid, out_result, out_flags and out_tag come directly from S4 registers. They stay stable while out_valid && !out_ready.
- Reset values:
  - All v_k = 0, so out_valid = 0.
  - out_result = 0, out_flags = 0, out_tag = 0.
  - in_ready = 1 in the first cycle after reset.
- Reset mid-operation discards all in-flight ops; no result is produced for them.
- Capacity is 4 ops. With out_ready held low, in_ready drops after the 4th accepted op.
- Simultaneous output transfer and input transfer while full proceeds without a bubble.

## Structure
- Package fp_pkg holds:
  - the rounding-mode enum (RM_RNE=0, RM_RTZ=1)
  - flag bit index constants (FLG_OF, FLG_UF, FLG_DZ, FLG_NV, FLG_NX)
  - a function returning the canonical qNaN for given EXP_W/MAN_W
- Sub-module fp_lzc: parametrised leading-zero counter (input width W, output $clog2(W+1)), instantiated in S3.

## Test plan
- Default params, RNE:
  - 0x3C00 + 0x4000 → 0x4200, flags 0, 4 cycles after accept.
  - 0x4200 − 0x4200 → 0x0000, flags 0.
- 0x7BFF + 0x7BFF:
  - RNE → 0x7C00, flags 5'b10001.
  - RTZ → 0x7BFF, flags 5'b10001.
- Special values:
  - 0x7C00 − 0x7C00 → 0x7E00, flags 5'b00010.
  - 0x7E00 + 0x3C00 → 0x7E00, flags 0.
- 0x3C00 + 0x1000 (1 + 2^−11, a tie):
  - RNE → 0x3C00, inexact.
  - 0x3C01 + 0x1000 → RNE 0x3C02 (round to even), RTZ 0x3C01, inexact in both.
- Backpressure:
  - Stream 8 ops with tags 0..7 and hold out_ready low for cycles 3–9. Expect in_ready low after 4 accepts, all 8 results in tag order, none lost or duplicated, outputs stable while stalled.
  - Assert rst while 3 ops are in flight: out_valid = 0 next cycle and no stale results afterwards.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the streaming floating-point add/sub datapath.
//   rm_e             : rounding-mode encoding carried with each operation
//   FLG_*            : bit positions inside the 5-bit exception flag vector
//   canonical_qnan() : canonical quiet NaN pattern for a given format, LSB-aligned
package fp_pkg;

    typedef enum logic {
        RM_RNE = 1'b0,
        RM_RTZ = 1'b1
    } rm_e;

    localparam int FLAGS_W = 5;
    localparam int FLG_OF  = 4;
    localparam int FLG_UF  = 3;
    localparam int FLG_DZ  = 2;
    localparam int FLG_NV  = 1;
    localparam int FLG_NX  = 0;

    // Sign 0, exponent all ones, mantissa MSB set, everything else clear.
    // Returned in 64 bits; callers truncate to their own word width.
    function automatic logic [63:0] canonical_qnan(input int exp_w, input int man_w);
        logic [63:0] q;
        q = '0;
        for (int i = 0; i < exp_w; i++) begin
            q[man_w + i] = 1'b1;
        end
        q[man_w - 1] = 1'b1;
        return q;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter.
//   value : input word, W bits
//   count : number of leading zeros of value; equals W when value is zero
module fp_lzc #(
    parameter int W  = 16,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);

    // Scan upward so the highest set bit is the last one to write count.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_addsub_stream.sv
// Four-stage pipelined floating-point adder/subtractor with valid/ready
// handshakes on both sides, per-operation rounding mode and a sideband tag.
//   clk, rst               : clock, synchronous active-high reset
//   in_valid / in_ready    : input handshake
//   in_a, in_b             : operands {sign, exp, man}
//   in_op                  : 0 = a+b, 1 = a-b
//   in_rm                  : 0 = round-nearest-even, 1 = round-toward-zero
//   in_tag                 : sideband tag, returned unchanged with the result
//   out_valid / out_ready  : output handshake
//   out_result, out_flags  : result and {OF, UF, DZ, NV, NX}
//   out_tag                : tag of this result
// Stages: S1 unpack/compare, S2 align, S3 add + leading-zero count,
// S4 normalise/round/pack. Subnormal inputs are read as zero and tiny
// results flush to signed zero.
module fp_addsub_stream
    import fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   in_op,
    input  logic                   in_rm,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic [FLAGS_W-1:0]     out_flags,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int EXTW = MAN_W + 4;           // hidden + mantissa + G/R/S
    localparam int SUMW = MAN_W + 5;           // EXTW plus carry
    localparam int LZW  = $clog2(SUMW + 1);
    localparam int DW   = EXP_W + 1;
    localparam int EW   = ((EXP_W > LZW) ? EXP_W : LZW) + 2;  // signed exponent math

    localparam logic [EXP_W-1:0]    EXP_ONES = '1;
    localparam logic [EXP_W-1:0]    EXP_MAXF = EXP_ONES - EXP_W'(1);
    localparam logic [W-1:0]        QNAN     = W'(canonical_qnan(EXP_W, MAN_W));
    localparam logic signed [EW-1:0] ONE_S   = EW'(1);
    localparam logic signed [EW-1:0] EMAX_S  = EW'((2 ** EXP_W) - 1);

    // ------------------------------------------------------------------
    // Pipeline control: a stage may load when it is empty or its
    // successor will take its contents this cycle.
    // ------------------------------------------------------------------
    logic v1_reg, v2_reg, v3_reg, v4_reg;
    logic ready1, ready2, ready3, ready4;

    assign ready4   = !v4_reg || out_ready;
    assign ready3   = !v3_reg || ready4;
    assign ready2   = !v2_reg || ready3;
    assign ready1   = !v1_reg || ready2;
    assign in_ready = ready1;

    // ------------------------------------------------------------------
    // S1: unpack, classify, order by magnitude
    // ------------------------------------------------------------------
    logic                   a_sign, b_sign;
    logic [EXP_W-1:0]       a_exp, b_exp;
    logic [MAN_W-1:0]       a_man, b_man;
    logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic [EXP_W+MAN_W-1:0] a_mag, b_mag;
    logic [MAN_W:0]         a_sig, b_sig;
    logic                   a_big, inf_inf;
    logic [EXP_W-1:0]       l_exp_next, s_exp;
    logic [MAN_W:0]         l_sig_next, s_sig_next;
    logic                   l_sign_next, sub_next, spec_next, neg_zero_next;
    logic [DW-1:0]          diff_next;
    logic [W-1:0]           spec_res_next;
    logic [FLAGS_W-1:0]     spec_flags_next;

    assign a_sign = in_a[W-1];
    assign a_exp  = in_a[W-2:MAN_W];
    assign a_man  = in_a[MAN_W-1:0];
    assign b_sign = in_b[W-1] ^ in_op;     // subtraction is addition of -b
    assign b_exp  = in_b[W-2:MAN_W];
    assign b_man  = in_b[MAN_W-1:0];

    always_comb begin
        a_zero = (a_exp == '0);
        b_zero = (b_exp == '0);
        a_inf  = (a_exp == EXP_ONES) && (a_man == '0);
        b_inf  = (b_exp == EXP_ONES) && (b_man == '0);
        a_nan  = (a_exp == EXP_ONES) && (a_man != '0);
        b_nan  = (b_exp == EXP_ONES) && (b_man != '0);
        a_snan = a_nan && !a_man[MAN_W-1];
        b_snan = b_nan && !b_man[MAN_W-1];

        // Subnormals read as zero, so their magnitude and significand vanish.
        a_mag = a_zero ? '0 : {a_exp, a_man};
        b_mag = b_zero ? '0 : {b_exp, b_man};
        a_sig = a_zero ? '0 : {1'b1, a_man};
        b_sig = b_zero ? '0 : {1'b1, b_man};

        a_big       = (a_mag >= b_mag);
        l_exp_next  = a_big ? a_mag[EXP_W+MAN_W-1:MAN_W] : b_mag[EXP_W+MAN_W-1:MAN_W];
        s_exp       = a_big ? b_mag[EXP_W+MAN_W-1:MAN_W] : a_mag[EXP_W+MAN_W-1:MAN_W];
        l_sig_next  = a_big ? a_sig : b_sig;
        s_sig_next  = a_big ? b_sig : a_sig;
        l_sign_next = a_big ? a_sign : b_sign;
        diff_next   = {1'b0, l_exp_next} - {1'b0, s_exp};
        sub_next    = a_sign ^ b_sign;

        inf_inf       = a_inf && b_inf && sub_next;
        spec_next     = a_nan || b_nan || a_inf || b_inf;
        neg_zero_next = a_zero && b_zero && a_sign && b_sign;

        spec_flags_next         = '0;
        spec_flags_next[FLG_NV] = a_snan || b_snan || inf_inf;
        if (a_nan || b_nan || inf_inf) begin
            spec_res_next = QNAN;
        end else if (a_inf) begin
            spec_res_next = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
            spec_res_next = {b_sign, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    logic               s1_sign_reg, s1_sub_reg, s1_spec_reg, s1_neg_zero_reg;
    logic [EXP_W-1:0]   s1_exp_reg;
    logic [MAN_W:0]     s1_lsig_reg, s1_ssig_reg;
    logic [DW-1:0]      s1_diff_reg;
    logic [W-1:0]       s1_spec_res_reg;
    logic [FLAGS_W-1:0] s1_spec_flags_reg;
    rm_e                s1_rm_reg;
    logic [TAG_W-1:0]   s1_tag_reg;

    // ------------------------------------------------------------------
    // S2: align the smaller significand with guard/round/sticky
    // ------------------------------------------------------------------
    logic [EXTW-1:0] ext_s, shifted, lost_mask, s2_s_next;
    logic [31:0]     shift32;

    always_comb begin
        ext_s     = {s1_ssig_reg, 3'b000};
        shift32   = 32'(s1_diff_reg);
        shifted   = ext_s >> s1_diff_reg;
        lost_mask = ~({EXTW{1'b1}} << s1_diff_reg);
        if (shift32 >= 32'(MAN_W + 3)) begin
            // Everything lands below the round bit: only stickiness survives.
            s2_s_next = {{(EXTW-1){1'b0}}, |s1_ssig_reg};
        end else begin
            s2_s_next = {shifted[EXTW-1:1], shifted[0] | (|(ext_s & lost_mask))};
        end
    end

    logic               s2_sign_reg, s2_sub_reg, s2_spec_reg, s2_neg_zero_reg;
    logic [EXP_W-1:0]   s2_exp_reg;
    logic [EXTW-1:0]    s2_l_reg, s2_s_reg;
    logic [W-1:0]       s2_spec_res_reg;
    logic [FLAGS_W-1:0] s2_spec_flags_reg;
    rm_e                s2_rm_reg;
    logic [TAG_W-1:0]   s2_tag_reg;

    // ------------------------------------------------------------------
    // S3: effective add/subtract and leading-zero count
    // ------------------------------------------------------------------
    logic [SUMW-1:0] sum_next;
    logic [LZW-1:0]  lz_next;

    // Larger magnitude is always the minuend, so the difference is never negative.
    assign sum_next = s2_sub_reg ? ({1'b0, s2_l_reg} - {1'b0, s2_s_reg})
                                 : ({1'b0, s2_l_reg} + {1'b0, s2_s_reg});

    fp_lzc #(
        .W  (SUMW),
        .CW (LZW)
    ) u_lzc (
        .value (sum_next),
        .count (lz_next)
    );

    logic               s3_sign_reg, s3_spec_reg, s3_neg_zero_reg;
    logic [EXP_W-1:0]   s3_exp_reg;
    logic [SUMW-1:0]    s3_sum_reg;
    logic [LZW-1:0]     s3_lz_reg;
    logic [W-1:0]       s3_spec_res_reg;
    logic [FLAGS_W-1:0] s3_spec_flags_reg;
    rm_e                s3_rm_reg;
    logic [TAG_W-1:0]   s3_tag_reg;

    // ------------------------------------------------------------------
    // S4: normalise, round, pack
    // ------------------------------------------------------------------
    logic [SUMW-1:0]        norm;
    logic signed [EW-1:0]   e_norm, e_rnd;
    logic [MAN_W-1:0]       mant, man_out;
    logic                   g_bit, r_bit, st_bit, inc, inexact;
    logic [MAN_W+1:0]       rnd;
    logic [W-1:0]           result_next;
    logic [FLAGS_W-1:0]     flags_next;

    always_comb begin
        // Normalise so the leading one sits in the carry position; the
        // exponent then gains one for the carry slot and loses the shift.
        norm    = s3_sum_reg << s3_lz_reg;
        e_norm  = EW'(s3_exp_reg) + EW'(1) - EW'(s3_lz_reg);
        mant    = norm[SUMW-2 -: MAN_W];
        g_bit   = norm[3];
        r_bit   = norm[2];
        st_bit  = |norm[1:0];
        inexact = g_bit || r_bit || st_bit;
        inc     = (s3_rm_reg == RM_RNE) && g_bit && (r_bit || st_bit || mant[0]);
        rnd     = {2'b01, mant} + (MAN_W+2)'(inc);
        // A carry out of rounding means the significand became 10.000...
        man_out = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        e_rnd   = e_norm + EW'(rnd[MAN_W+1]);

        result_next = '0;
        flags_next  = '0;
        flags_next[FLG_DZ] = 1'b0;
        if (s3_spec_reg) begin
            result_next = s3_spec_res_reg;
            flags_next  = s3_spec_flags_reg;
        end else if (!norm[SUMW-1]) begin
            // Exact zero sum (shift by full width leaves nothing).
            result_next = {s3_neg_zero_reg, {(W-1){1'b0}}};
        end else if (e_norm < ONE_S) begin
            result_next        = {s3_sign_reg, {(W-1){1'b0}}};
            flags_next[FLG_UF] = 1'b1;
            flags_next[FLG_NX] = 1'b1;
        end else if (e_rnd >= EMAX_S) begin
            flags_next[FLG_OF] = 1'b1;
            flags_next[FLG_NX] = 1'b1;
            if (s3_rm_reg == RM_RNE) begin
                result_next = {s3_sign_reg, EXP_ONES, {MAN_W{1'b0}}};
            end else begin
                result_next = {s3_sign_reg, EXP_MAXF, {MAN_W{1'b1}}};
            end
        end else begin
            result_next        = {s3_sign_reg, e_rnd[EXP_W-1:0], man_out};
            flags_next[FLG_NX] = inexact;
        end
    end

    logic [W-1:0]       s4_result_reg;
    logic [FLAGS_W-1:0] s4_flags_reg;
    logic [TAG_W-1:0]   s4_tag_reg;

    assign out_valid  = v4_reg;
    assign out_result = s4_result_reg;
    assign out_flags  = s4_flags_reg;
    assign out_tag    = s4_tag_reg;

    // ------------------------------------------------------------------
    // Valid bits and output registers (reset), then datapath registers.
    // A stage that is ready but whose predecessor is empty takes a bubble,
    // which is how gaps collapse while the output is stalled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg        <= 1'b0;
            v2_reg        <= 1'b0;
            v3_reg        <= 1'b0;
            v4_reg        <= 1'b0;
            s4_result_reg <= '0;
            s4_flags_reg  <= '0;
            s4_tag_reg    <= '0;
        end else begin
            if (ready1) v1_reg <= in_valid;
            if (ready2) v2_reg <= v1_reg;
            if (ready3) v3_reg <= v2_reg;
            if (ready4) begin
                v4_reg <= v3_reg;
                if (v3_reg) begin
                    s4_result_reg <= result_next;
                    s4_flags_reg  <= flags_next;
                    s4_tag_reg    <= s3_tag_reg;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ready1 && in_valid) begin
            s1_sign_reg       <= l_sign_next;
            s1_sub_reg        <= sub_next;
            s1_spec_reg       <= spec_next;
            s1_neg_zero_reg   <= neg_zero_next;
            s1_exp_reg        <= l_exp_next;
            s1_lsig_reg       <= l_sig_next;
            s1_ssig_reg       <= s_sig_next;
            s1_diff_reg       <= diff_next;
            s1_spec_res_reg   <= spec_res_next;
            s1_spec_flags_reg <= spec_flags_next;
            s1_rm_reg         <= rm_e'(in_rm);
            s1_tag_reg        <= in_tag;
        end
        if (ready2 && v1_reg) begin
            s2_sign_reg       <= s1_sign_reg;
            s2_sub_reg        <= s1_sub_reg;
            s2_spec_reg       <= s1_spec_reg;
            s2_neg_zero_reg   <= s1_neg_zero_reg;
            s2_exp_reg        <= s1_exp_reg;
            s2_l_reg          <= {s1_lsig_reg, 3'b000};
            s2_s_reg          <= s2_s_next;
            s2_spec_res_reg   <= s1_spec_res_reg;
            s2_spec_flags_reg <= s1_spec_flags_reg;
            s2_rm_reg         <= s1_rm_reg;
            s2_tag_reg        <= s1_tag_reg;
        end
        if (ready3 && v2_reg) begin
            s3_sign_reg       <= s2_sign_reg;
            s3_spec_reg       <= s2_spec_reg;
            s3_neg_zero_reg   <= s2_neg_zero_reg;
            s3_exp_reg        <= s2_exp_reg;
            s3_sum_reg        <= sum_next;
            s3_lz_reg         <= lz_next;
            s3_spec_res_reg   <= s2_spec_res_reg;
            s3_spec_flags_reg <= s2_spec_flags_reg;
            s3_rm_reg         <= s2_rm_reg;
            s3_tag_reg        <= s2_tag_reg;
        end
    end

endmodule

// File: tb/tb_fp_addsub_stream.sv
// Directed testbench for fp_addsub_stream (default half-precision format).
// Checks reset state, arithmetic/rounding/special-value vectors with their
// latency, backpressure ordering/stability, and reset while ops are in flight.
module tb_fp_addsub_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a, in_b;
    logic        in_op, in_rm;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [4:0]  out_flags;
    logic [3:0]  out_tag;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_addsub_stream #(
        .EXP_W (5),
        .MAN_W (10),
        .TAG_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_rm      (in_rm),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_tag    (out_tag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // One operation with out_ready high; result must appear 4 cycles after accept.
    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic op, input logic rm, input logic [3:0] tag,
                          input logic [15:0] want_res, input logic [4:0] want_flags);
        int lat;
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_rm    = rm;
        in_tag   = tag;
        in_valid = 1'b1;
        check({name, "/in_ready"}, 32'(in_ready), 32'(1));
        @(posedge clk);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (out_valid) break;
        end
        check({name, "/latency"}, lat, 4);
        check({name, "/result"}, 32'(out_result), 32'(want_res));
        check({name, "/flags"}, 32'(out_flags), 32'(want_flags));
        check({name, "/tag"}, 32'(out_tag), 32'(tag));
        $display("op %s: a=%h b=%h op=%0d rm=%0d -> result=%h flags=%b tag=%0d latency=%0d",
                 name, a, b, op, rm, out_result, out_flags, out_tag, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = 1'b0;
        in_rm     = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst/out_valid", 32'(out_valid), 32'(0));
        check("rst/out_result", 32'(out_result), 32'(0));
        check("rst/out_flags", 32'(out_flags), 32'(0));
        check("rst/out_tag", 32'(out_tag), 32'(0));
        check("rst/in_ready", 32'(in_ready), 32'(1));

        //      name               a         b         op    rm    tag    result    flags
        run_op("add_basic",      16'h3C00, 16'h4000, 1'b0, 1'b0, 4'd1,  16'h4200, 5'b00000);
        run_op("sub_to_zero",    16'h4200, 16'h4200, 1'b1, 1'b0, 4'd2,  16'h0000, 5'b00000);
        run_op("ovf_rne",        16'h7BFF, 16'h7BFF, 1'b0, 1'b0, 4'd3,  16'h7C00, 5'b10001);
        run_op("ovf_rtz",        16'h7BFF, 16'h7BFF, 1'b0, 1'b1, 4'd4,  16'h7BFF, 5'b10001);
        run_op("inf_minus_inf",  16'h7C00, 16'h7C00, 1'b1, 1'b0, 4'd5,  16'h7E00, 5'b00010);
        run_op("qnan_prop",      16'h7E00, 16'h3C00, 1'b0, 1'b0, 4'd6,  16'h7E00, 5'b00000);
        run_op("tie_even_down",  16'h3C00, 16'h1000, 1'b0, 1'b0, 4'd7,  16'h3C00, 5'b00001);
        run_op("tie_even_up",    16'h3C01, 16'h1000, 1'b0, 1'b0, 4'd8,  16'h3C02, 5'b00001);
        run_op("tie_rtz",        16'h3C01, 16'h1000, 1'b0, 1'b1, 4'd9,  16'h3C01, 5'b00001);
        run_op("neg_zero",       16'h8000, 16'h8000, 1'b0, 1'b0, 4'd10, 16'h8000, 5'b00000);
        run_op("mixed_zero",     16'h8000, 16'h0000, 1'b0, 1'b0, 4'd11, 16'h0000, 5'b00000);
        run_op("underflow",      16'h0401, 16'h0400, 1'b1, 1'b0, 4'd12, 16'h0000, 5'b01001);
        run_op("daz_subnormal",  16'h3C00, 16'h0001, 1'b0, 1'b0, 4'd13, 16'h3C00, 5'b00000);
        run_op("snan",           16'h7C01, 16'h3C00, 1'b0, 1'b0, 4'd14, 16'h7E00, 5'b00010);
        run_op("inf_operand",    16'h3C00, 16'h7C00, 1'b1, 1'b0, 4'd15, 16'hFC00, 5'b00000);
        run_op("sub_borrow",     16'h3C00, 16'h3800, 1'b1, 1'b0, 4'd0,  16'h3800, 5'b00000);
        run_op("neg_mix",        16'hBC00, 16'h3800, 1'b0, 1'b0, 4'd1,  16'hB800, 5'b00000);
        run_op("round_ovf_rne",  16'h7BFF, 16'h4F00, 1'b0, 1'b0, 4'd2,  16'h7C00, 5'b10001);
        run_op("round_rtz_max",  16'h7BFF, 16'h4F00, 1'b0, 1'b1, 4'd3,  16'h7BFF, 5'b00001);

        // Backpressure: 8 ops (a = 1.0 + t ulp, b = 0, tag = t), out_ready low cycles 3..9.
        begin : bp
            int          sent;
            int          rx;
            logic        held_v;
            logic        seen_drop;
            logic [15:0] held_res;
            logic [4:0]  held_flags;
            logic [3:0]  held_tag;
            sent       = 0;
            rx         = 0;
            held_v     = 1'b0;
            seen_drop  = 1'b0;
            held_res   = '0;
            held_flags = '0;
            held_tag   = '0;
            for (int cyc = 0; cyc < 60; cyc++) begin
                @(negedge clk);
                out_ready = !(cyc >= 3 && cyc <= 9);
                in_valid  = (sent < 8);
                in_a      = 16'h3C00 + 16'(sent);
                in_b      = 16'h0000;
                in_op     = 1'b0;
                in_rm     = 1'b0;
                in_tag    = 4'(sent);
                #1;
                if (held_v) begin
                    check("bp/stall_valid", 32'(out_valid), 32'(1));
                    check("bp/stall_result", 32'(out_result), 32'(held_res));
                    check("bp/stall_flags", 32'(out_flags), 32'(held_flags));
                    check("bp/stall_tag", 32'(out_tag), 32'(held_tag));
                end
                if (out_valid && out_ready) begin
                    if (rx < 8) begin
                        check("bp/tag", 32'(out_tag), rx);
                        check("bp/result", 32'(out_result), 32'(16'h3C00) + 32'(rx));
                        check("bp/flags", 32'(out_flags), 32'(0));
                    end
                    $display("bp result: cycle=%0d result=%h flags=%b tag=%0d",
                             cyc, out_result, out_flags, out_tag);
                    rx++;
                end
                held_v     = out_valid && !out_ready;
                held_res   = out_result;
                held_flags = out_flags;
                held_tag   = out_tag;
                if (cyc >= 4 && cyc <= 9) begin
                    check("bp/in_ready_full", 32'(in_ready), 32'(0));
                end
                if (in_valid && !in_ready && !seen_drop) begin
                    seen_drop = 1'b1;
                    check("bp/accepts_before_full", sent, 4);
                end
                if (in_valid && in_ready) sent++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            check("bp/sent", sent, 8);
            check("bp/received", rx, 8);
        end

        // Reset with three ops in flight: nothing may emerge afterwards.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 16'h3C00;
            in_b     = 16'h4000;
            in_op    = 1'b0;
            in_rm    = 1'b0;
            in_tag   = 4'hA + 4'(i);
            check("rstfl/in_ready", 32'(in_ready), 32'(1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstfl/out_valid", 32'(out_valid), 32'(0));
        check("rstfl/in_ready", 32'(in_ready), 32'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rstfl/no_stale", 32'(out_valid), 32'(0));
        end
        $display("rst flush: 3 in-flight ops discarded");
        run_op("after_reset",    16'h3C00, 16'h4000, 1'b0, 1'b0, 4'd5,  16'h4200, 5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
